echo_fx: RTL and testbench

Feedback echo effect that sits between the I2S receive stream and the I2S transmit stream, clocked on the 100 MHz fabric clock. It accepts one signed audio sample per input-valid pulse, stores samples in an on-chip circular buffer, and returns the dry sample plus a scaled copy of the buffered output from `delay` samples earlier. Buffer contents are zero-cleared after every reset.

---
 rtl/echo_fx_if.sv | 33 +++
 rtl/echo_fx.sv | 145 ++++++++++++++
 tb/tb_echo_fx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/echo_fx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : echo_fx_if
// Brief    : Sample stream, control and status bundle for the echo effect.
// Revision : 1.0 - initial release
// ============================================================================
interface echo_fx_if #(
    parameter int SAMPLE_W = 24,
    parameter int ADDR_W   = 14,
    parameter int GAIN_W   = 8
);
    logic [SAMPLE_W-1:0] in_data;
    logic                in_vld;
    logic [ADDR_W-1:0]   delay;
    logic [GAIN_W-1:0]   mix;
    logic                bypass;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_vld;
    logic                busy;
    logic                overrun;

    modport master (
        output in_data, in_vld, delay, mix, bypass,
        input  out_data, out_vld, busy, overrun
    );

    modport slave (
        input  in_data, in_vld, delay, mix, bypass,
        output out_data, out_vld, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/echo_fx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : echo_fx
// Brief    : Feedback echo: dry sample plus scaled buffered output from
//            `delay` samples earlier. Define ECHO_FX_SAT_EN to saturate sums.
// Revision : 1.0 - initial release
// ============================================================================
module echo_fx #(
    parameter int SAMPLE_W = 24,
    parameter int ADDR_W   = 14,
    parameter int GAIN_W   = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    echo_fx_if.slave   bus
);
    localparam int c_PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [SAMPLE_W-1:0] r_x;
    logic [ADDR_W-1:0]   r_delay;
    logic [GAIN_W-1:0]   r_mix;
    logic                r_bypass;
    logic [SAMPLE_W-1:0] r_rd_data;
    logic [SAMPLE_W-1:0] r_out_data;
    logic                r_out_vld;
    logic                r_busy;
    logic                r_overrun;

    logic [SAMPLE_W-1:0] r_mem [2**ADDR_W];

    logic                       w_we;
    logic [ADDR_W-1:0]          w_waddr;
    logic [SAMPLE_W-1:0]        w_wdata;
    logic [SAMPLE_W-1:0]        w_tap;
    logic signed [c_PROD_W-1:0] w_prod;
    logic [SAMPLE_W:0]          w_wet;
    logic [SAMPLE_W:0]          w_sum_ext;
    logic [SAMPLE_W-1:0]        w_sum;
    logic [SAMPLE_W-1:0]        w_y;

    // The result register doubles as the write-back data during WRITE.
    assign w_we    = (r_state == S_CLEAR) || (r_state == S_WRITE);
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_wr_ptr;
    assign w_wdata = (r_state == S_CLEAR) ? '0 : r_out_data;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= r_mem[r_rd_addr];
    end

    always_comb begin
        w_tap     = (r_delay == '0) ? '0 : r_rd_data;
        w_prod    = $signed({{(c_PROD_W-SAMPLE_W){w_tap[SAMPLE_W-1]}}, w_tap})
                  * $signed({{(c_PROD_W-GAIN_W){1'b0}}, r_mix});
        w_wet     = (SAMPLE_W+1)'(w_prod >>> GAIN_W);
        w_sum_ext = {r_x[SAMPLE_W-1], r_x} + w_wet;
`ifdef ECHO_FX_SAT_EN
        if (w_sum_ext[SAMPLE_W] != w_sum_ext[SAMPLE_W-1]) begin
            w_sum = w_sum_ext[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                        : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            w_sum = w_sum_ext[SAMPLE_W-1:0];
        end
`else
        w_sum = SAMPLE_W'(w_sum_ext);
`endif
        w_y = r_bypass ? r_x : w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_busy     <= 1'b1;
            r_overrun  <= 1'b0;
        end else begin
            r_out_vld <= 1'b0;
            // Drops during the initial clear are expected and not flagged.
            if (bus.in_vld && (r_state == S_READ || r_state == S_CALC ||
                               r_state == S_WRITE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_ADDR_MAX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (bus.in_vld) begin
                        r_x       <= bus.in_data;
                        r_delay   <= bus.delay;
                        r_mix     <= bus.mix;
                        r_bypass  <= bus.bypass;
                        r_rd_addr <= r_wr_ptr - bus.delay;
                        r_state   <= S_READ;
                        r_busy    <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_out_data <= w_y;
                    r_out_vld  <= 1'b1;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.out_vld  = r_out_vld;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_echo_fx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_echo_fx
// Brief    : Self-checking bench for echo_fx against a sample-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_echo_fx;
    localparam int SW = 24;
    localparam int AW = 4;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    echo_fx_if #(.SAMPLE_W(SW), .ADDR_W(AW), .GAIN_W(GW)) bus ();
    echo_fx #(.SAMPLE_W(SW), .ADDR_W(AW), .GAIN_W(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int vld_cnt = 0;
    longint hist[$];

    always @(negedge clk) if (bus.out_vld === 1'b1) vld_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each output is the dry sample plus gain times the output emitted
    // `d` samples ago (zero before enough history exists after a clear).
    function automatic longint model(input longint x, input int d, input int m,
                                     input bit byp);
        longint tap, wet, s;
        logic signed [63:0] full;
        logic signed [SW-1:0] w;
        tap = 0;
        if (d != 0 && hist.size() >= d) tap = hist[hist.size() - d];
        wet  = (tap * m) >>> GW;
        s    = x + wet;
`ifdef ECHO_FX_SAT_EN
        if (s > 64'sd8388607)  s = 8388607;
        if (s < -64'sd8388608) s = -8388608;
`else
        full = s;
        w    = full[SW-1:0];
        s    = w;
`endif
        if (byp) s = x;
        hist.push_back(s);
        return s;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (bus.busy !== 1'b0) check("ready_timeout", bus.busy, 0);
    endtask

    task automatic send(input longint x, input int d, input int m, input bit byp,
                        output logic signed [63:0] y, output int lat);
        logic signed [63:0] xv;
        wait_ready();
        xv = x;
        bus.in_data = xv[SW-1:0];
        bus.delay   = AW'(d);
        bus.mix     = GW'(m);
        bus.bypass  = byp;
        bus.in_vld  = 1'b1;
        lat = -1;
        y   = 'x;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            bus.in_vld = 1'b0;
            if (bus.out_vld === 1'b1 && lat < 0) begin
                lat = i;
                y   = $signed(bus.out_data);
            end
        end
    endtask

    task automatic do_sample(input string tag, input longint x, input int d,
                             input int m, input bit byp,
                             output logic signed [63:0] y);
        longint exp;
        int lat;
        exp = model(x, d, m, byp);
        send(x, d, m, byp, y, lat);
        check(tag, y, exp);
        check({tag, "_lat"}, lat, 3);
    endtask

    task automatic release_and_clear(input bit poke);
        int cnt = 0;
        int v0  = vld_cnt;
        rst = 1'b0;
        hist.delete();
        for (int i = 0; i < 40; i++) begin
            bus.in_vld = (poke && i == 5);
            if (bus.busy !== 1'b1) break;
            cnt++;
            @(posedge clk); #1;
        end
        bus.in_vld = 1'b0;
        check("clear_len", cnt, 16);
        check("clear_overrun", bus.overrun, 0);
        check("clear_no_vld", vld_cnt - v0, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        release_and_clear(1'b0);
    endtask

    initial begin
        logic signed [63:0] y;
        logic signed [SW-1:0] r;
        longint x;
        int lat;
        int v0;
        longint echo_in[5]  = '{1000, 0, 0, 0, 0};
        longint echo_exp[5] = '{1000, 0, 500, 0, 250};

        bus.in_vld = 1'b0; bus.in_data = '0; bus.delay = '0;
        bus.mix = '0; bus.bypass = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_out_data", bus.out_data, 0);

        // Clear phase with a stray strobe, then a zeroed-buffer read.
        release_and_clear(1'b1);
        r = SW'($urandom);
        x = r;
        do_sample("first_after_clear", x, 3, 255, 1'b0, y);
        check("first_is_dry", y, x);

        // Decaying echo.
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            void'(model(echo_in[k], 2, 128, 1'b0));
            send(echo_in[k], 2, 128, 1'b0, y, lat);
            check("echo_val", y, echo_exp[k]);
            check("echo_lat", lat, 3);
        end

        // Pointer wrap with the longest delay.
        pulse_reset();
        for (int k = 1; k <= 20; k++) begin
            do_sample("wrap", 16, 15, 255, 1'b0, y);
            if (k == 17) check("wrap_out17", y, 31);
        end

        // Random traffic.
        for (int k = 0; k < 24; k++) begin
            r = SW'($urandom);
            x = r;
            do_sample("rand", x, int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), y);
        end

        // Positive and negative limits.
        pulse_reset();
        do_sample("sat_p0", 8388607, 1, 255, 1'b0, y);
        do_sample("sat_p1", 0, 1, 255, 1'b0, y);
        do_sample("sat_p2", 8388607, 1, 255, 1'b0, y);
`ifdef ECHO_FX_SAT_EN
        check("sat_pos_clamp", y, 8388607);
`else
        check("sat_pos_wraps_neg", (y < 0), 1);
`endif
        pulse_reset();
        do_sample("sat_n0", -8388608, 1, 255, 1'b0, y);
        do_sample("sat_n1", 0, 1, 255, 1'b0, y);
        do_sample("sat_n2", -8388608, 1, 255, 1'b0, y);
`ifdef ECHO_FX_SAT_EN
        check("sat_neg_clamp", y, -8388608);
`else
        check("sat_neg_wraps_pos", (y > 0), 1);
`endif

        // Second strobe two cycles after an accept is dropped.
        wait_ready();
        v0 = vld_cnt;
        x  = model(777, 0, 0, 1'b0);
        bus.in_data = SW'(777); bus.delay = '0; bus.mix = '0; bus.bypass = 1'b0;
        bus.in_vld = 1'b1;
        @(posedge clk); #1; bus.in_vld = 1'b0;
        @(posedge clk); #1; bus.in_vld = 1'b1;
        @(posedge clk); #1; bus.in_vld = 1'b0;
        check("ovr_flag_n3", bus.overrun, 1);
        check("ovr_out_vld", bus.out_vld, 1);
        check("ovr_out_data", $signed(bus.out_data), x);
        repeat (6) @(posedge clk);
        #1;
        check("ovr_single_vld", vld_cnt - v0, 1);
        check("ovr_sticky", bus.overrun, 1);
        do_sample("bypass", -1234, 5, 200, 1'b1, y);
        check("bypass_dry", y, -1234);

        // Reset during a sample aborts it and restarts the clear.
        wait_ready();
        v0 = vld_cnt;
        bus.in_data = SW'(4321); bus.delay = AW'(1); bus.mix = GW'(100);
        bus.bypass = 1'b0; bus.in_vld = 1'b1;
        @(posedge clk); #1; bus.in_vld = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        release_and_clear(1'b0);
        check("abort_no_vld", vld_cnt - v0, 0);
        do_sample("after_abort", 5000, 1, 255, 1'b0, y);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
